// File: rtl/seq_pkg.sv
// Shared definitions for the 4-bit sequence generator / checker pair.
// Holds the repeating 8-symbol pattern, its length, and the checker FSM state encoding.
// No ports; imported by seq_rom and sequence_checker.
package seq_pkg;

   localparam int SEQ_LEN = 8;

   // Pattern emitted by the generator, index 0 first.
   localparam logic [3:0] SEQ [SEQ_LEN] = '{4'hA, 4'hB, 4'hE, 4'h7,
                                            4'hF, 4'h2, 4'h0, 4'hD};

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   function automatic logic [3:0] seq_sym(input logic [2:0] idx);
      return SEQ[idx];
   endfunction

endpackage

// File: rtl/seq_rom.sv
// Purpose: combinational lookup of the pattern symbol at a given index.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; always answers.
// Ports: idx (3-bit pattern position) -> sym (4-bit symbol at that position).
module seq_rom
   import seq_pkg::*;
(
   input  logic [2:0] idx,
   output logic [3:0] sym
);

   assign sym = seq_sym(idx);

endmodule

// File: rtl/sequence_checker.sv
// Purpose: aligns to and tracks the A,B,E,7,F,2,0,D generator stream; flags errors and frames.
// Latency: a sample taken at a rising edge is reflected on all outputs right after that edge.
// Backpressure: none; in_valid=0 simply freezes tracking state for that cycle.
// Ports: clk, reset_n (sync, active-low), in_valid/in_data (sampled symbol),
//        locked, mismatch (pulse), frame_done (pulse), expected (next symbol), err_count.
module sequence_checker
   import seq_pkg::*;
#(
   parameter int LOCK_THRESH = 8,
   parameter int LOSS_THRESH = 3,
   parameter int ERR_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   output logic             locked,
   output logic             mismatch,
   output logic             frame_done,
   output logic [3:0]       expected,
   output logic [ERR_W-1:0] err_count
);

   localparam int MW = $clog2(LOCK_THRESH + 1);
   localparam int LW = $clog2(LOSS_THRESH + 1);

   state_e          state;
   logic [2:0]      idx;
   logic [MW-1:0]   match_cnt;
   logic [LW-1:0]   miss_cnt;

   logic [3:0]      exp_sym;
   logic            sym_match;
   logic            sym_is_a;
   logic [MW-1:0]   match_nxt;
   logic [LW-1:0]   miss_nxt;

   // Expected symbol comes only from the registered index, so in_data never
   // reaches an output combinationally.
   seq_rom u_rom (
      .idx (idx),
      .sym (exp_sym)
   );

   assign expected  = exp_sym;
   assign locked    = (state == LOCKED);
   assign sym_match = (in_data == exp_sym);
   assign sym_is_a  = (in_data == SEQ[0]);
   assign match_nxt = match_cnt + MW'(1);
   assign miss_nxt  = miss_cnt + LW'(1);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= HUNT;
         idx        <= 3'd0;
         match_cnt  <= '0;
         miss_cnt   <= '0;
         mismatch   <= 1'b0;
         frame_done <= 1'b0;
         err_count  <= '0;
      end else begin
         mismatch   <= 1'b0;
         frame_done <= 1'b0;
         if (in_valid) begin
            case (state)
               HUNT: begin
                  if (sym_is_a) begin
                     idx <= 3'd1;
                     if (LOCK_THRESH == 1) begin
                        state     <= LOCKED;
                        match_cnt <= '0;
                     end else begin
                        state     <= VERIFY;
                        match_cnt <= MW'(1);
                     end
                  end else begin
                     idx <= 3'd0;
                  end
               end

               VERIFY: begin
                  if (sym_match) begin
                     idx <= idx + 3'd1;
                     if (match_nxt == MW'(LOCK_THRESH)) begin
                        state     <= LOCKED;
                        match_cnt <= '0;
                     end else begin
                        match_cnt <= match_nxt;
                     end
                  end else if (sym_is_a) begin
                     // A failed candidate may itself be the start of the real frame.
                     idx       <= 3'd1;
                     match_cnt <= MW'(1);
                  end else begin
                     state     <= HUNT;
                     idx       <= 3'd0;
                     match_cnt <= '0;
                  end
               end

               LOCKED: begin
                  if (sym_match) begin
                     idx        <= idx + 3'd1;
                     miss_cnt   <= '0;
                     frame_done <= (idx == 3'd7);
                  end else begin
                     mismatch <= 1'b1;
                     if (!(&err_count)) begin
                        err_count <= err_count + ERR_W'(1);
                     end
                     if (miss_nxt == LW'(LOSS_THRESH)) begin
                        state     <= HUNT;
                        idx       <= 3'd0;
                        miss_cnt  <= '0;
                        match_cnt <= '0;
                     end else begin
                        // Flywheel: keep stepping through the pattern across errors.
                        idx      <= idx + 3'd1;
                        miss_cnt <= miss_nxt;
                     end
                  end
               end

               default: begin
                  state     <= HUNT;
                  idx       <= 3'd0;
                  match_cnt <= '0;
                  miss_cnt  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sequence_checker.sv
module tb_sequence_checker;

   typedef struct {
      bit         rst;
      bit         sel;
      logic       vld;
      logic [3:0] dat;
      logic       lk;
      logic       mm;
      logic       fd;
      logic [3:0] ex;
      int         err;
      string      tag;
   } vec_t;

   localparam logic [3:0] TB_SEQ [8] = '{4'hA, 4'hB, 4'hE, 4'h7,
                                         4'hF, 4'h2, 4'h0, 4'hD};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        vld1 = 1'b0, vld2 = 1'b0;
   logic [3:0]  dat1 = 4'h0, dat2 = 4'h0;
   logic        lk1, mm1, fd1, lk2, mm2, fd2;
   logic [3:0]  ex1, ex2;
   logic [15:0] err1;
   logic [1:0]  err2;

   int tests = 0;
   int fails = 0;
   string grp = "";

   vec_t vecs[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   sequence_checker #(.LOCK_THRESH(8), .LOSS_THRESH(3), .ERR_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(vld1), .in_data(dat1),
      .locked(lk1), .mismatch(mm1), .frame_done(fd1), .expected(ex1), .err_count(err1)
   );

   sequence_checker #(.LOCK_THRESH(1), .LOSS_THRESH(8), .ERR_W(2)) dut_sat (
      .clk(clk), .reset_n(reset_n), .in_valid(vld2), .in_data(dat2),
      .locked(lk2), .mismatch(mm2), .frame_done(fd2), .expected(ex2), .err_count(err2)
   );

   task automatic add(input bit rst, input bit sel, input logic vld, input logic [3:0] dat,
                      input logic lk, input logic mm, input logic fd,
                      input logic [3:0] ex, input int err);
      vec_t v;
      v.rst = rst; v.sel = sel; v.vld = vld; v.dat = dat;
      v.lk = lk; v.mm = mm; v.fd = fd; v.ex = ex; v.err = err; v.tag = grp;
      vecs.push_back(v);
   endtask

   task automatic add_rst(input bit sel);
      add(1'b1, sel, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'hA, 0);
   endtask

   // Acquisition rows from pattern position 'start' through the locking D.
   task automatic acquire_from(input int start, input int err, input bit gap);
      for (int i = start; i < 8; i++) begin
         add(1'b0, 1'b0, 1'b1, TB_SEQ[i], (i == 7), 1'b0, 1'b0, TB_SEQ[(i + 1) % 8], err);
         if (gap)
            add(1'b0, 1'b0, 1'b0, 4'h5, (i == 7), 1'b0, 1'b0, TB_SEQ[(i + 1) % 8], err);
      end
   endtask

   // One full frame while locked; optional single symbol replaced by 5.
   task automatic locked_frame(input int err, input int glitch, input bit gap);
      int e;
      logic [3:0] d;
      logic g;
      e = err;
      for (int i = 0; i < 8; i++) begin
         d = TB_SEQ[i];
         g = (i == glitch);
         if (g) begin
            d = 4'h5;
            e++;
         end
         add(1'b0, 1'b0, 1'b1, d, 1'b1, g, (i == 7) && !g, TB_SEQ[(i + 1) % 8], e);
         if (gap)
            add(1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, TB_SEQ[(i + 1) % 8], e);
      end
   endtask

   task automatic chk(input string tag, input int row, input string field,
                      input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s row %0d %s: got %0d, want %0d", tag, row, field, act, exp);
      end
   endtask

   initial begin
      vec_t v;
      vec_t e;

      grp = "reset";
      add_rst(1'b0);
      add_rst(1'b0);

      grp = "clean_lock";
      acquire_from(0, 0, 1'b0);
      locked_frame(0, -1, 1'b0);

      grp = "glitch";
      locked_frame(0, 4, 1'b0);

      grp = "loss";
      add_rst(1'b0);
      acquire_from(0, 0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 4'hB, 1);
      add(1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 4'hE, 2);
      add(1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'hA, 3);
      add(1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 4'hA, 3);
      grp = "reacquire";
      acquire_from(0, 3, 1'b0);
      locked_frame(3, -1, 1'b0);

      grp = "false_start";
      add_rst(1'b0);
      add(1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'hB, 0);
      add(1'b0, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 4'hE, 0);
      add(1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 4'hA, 0);
      acquire_from(0, 0, 1'b0);

      grp = "restart_on_a";
      add_rst(1'b0);
      add(1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'hB, 0);
      add(1'b0, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 4'hE, 0);
      add(1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'hB, 0);
      acquire_from(1, 0, 1'b0);
      locked_frame(0, -1, 1'b0);

      grp = "gaps";
      add_rst(1'b0);
      acquire_from(0, 0, 1'b1);
      locked_frame(0, 4, 1'b1);
      locked_frame(1, -1, 1'b1);

      grp = "saturate";
      add_rst(1'b1);
      add(1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 4'hB, 0);
      for (int k = 0; k < 8; k++)
         add(1'b0, 1'b1, 1'b1, 4'h3, (k < 7), 1'b1, 1'b0,
             (k < 7) ? TB_SEQ[(k + 2) % 8] : 4'hA, (k < 2) ? k + 1 : 3);
      add(1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 4'hB, 3);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         reset_n = !v.rst;
         if (v.sel) begin
            vld1 = 1'b0; dat1 = 4'h0;
            vld2 = v.vld; dat2 = v.dat;
         end else begin
            vld1 = v.vld; dat1 = v.dat;
            vld2 = 1'b0; dat2 = 4'h0;
         end
         sb.push_back(v);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         if (e.sel) begin
            chk(e.tag, i, "locked",     int'(lk2),  int'(e.lk));
            chk(e.tag, i, "mismatch",   int'(mm2),  int'(e.mm));
            chk(e.tag, i, "frame_done", int'(fd2),  int'(e.fd));
            chk(e.tag, i, "expected",   int'(ex2),  int'(e.ex));
            chk(e.tag, i, "err_count",  int'(err2), e.err);
         end else begin
            chk(e.tag, i, "locked",     int'(lk1),  int'(e.lk));
            chk(e.tag, i, "mismatch",   int'(mm1),  int'(e.mm));
            chk(e.tag, i, "frame_done", int'(fd1),  int'(e.fd));
            chk(e.tag, i, "expected",   int'(ex1),  int'(e.ex));
            chk(e.tag, i, "err_count",  int'(err1), e.err);
         end
      end

      chk("scoreboard", vecs.size(), "leftover", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
